// File: rtl/gc_conv_arbiter.sv
// gc_conv_arbiter: NREQ-way valid/ready arbiter feeding one shared binary-to-Gray converter with a registered output slot.
// Define GC_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority with the lowest index winning.
module gc_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int SW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_gray,
    output logic [W-1:0]    out_bin,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t         r_state, w_next;
    logic [W-1:0]   r_gray, r_bin;
    logic [SW-1:0]  r_src;
    logic [SW-1:0]  w_base, w_idx;
    logic           w_any, w_free, w_load;
    logic [W-1:0]   w_word;
`ifdef GC_ARB_ROUND_ROBIN_EN
    logic [SW-1:0]  r_ptr;
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= '0;
        else if (w_load) r_ptr <= (int'(w_idx) == NREQ-1) ? '0 : w_idx + 1'b1;
    end
    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif
    // Scan from the highest offset down so the requester closest to the base wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req_valid[(int'(w_base) + k) % NREQ]) begin
                w_any = 1'b1;
                w_idx = SW'((int'(w_base) + k) % NREQ);
            end
        end
    end
    assign w_free = (r_state == EMPTY) || out_ready;
    assign w_load = w_free && w_any && !rst;
    assign w_word = req_data[w_idx*W +: W];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_gray  <= '0;
            r_bin   <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_gray <= w_word ^ (w_word >> 1);
                r_bin  <= w_word;
                r_src  <= w_idx;
            end
        end
    end
    always_comb begin
        w_next = w_load ? FULL : (w_free ? EMPTY : r_state);
    end
    always_comb begin
        req_ready = '0;
        if (w_load) req_ready[w_idx] = 1'b1;
        out_valid = (r_state == FULL);
        out_gray  = r_gray;
        out_bin   = r_bin;
        out_src   = r_src;
    end
endmodule

// File: tb/tb_gc_conv_arbiter.sv
// tb_gc_conv_arbiter: directed table, corner sequences and randomized traffic checked against a behavioural model.
module tb_gc_conv_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int SW = 2;
`ifdef GC_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [W-1:0]  out_gray, out_bin;
    logic [SW-1:0] out_src;
    logic          out_ready = 1'b0;
    int            n_vec = 0;
    int            n_bad = 0;
    bit            m_ov = 1'b0;
    int            m_gray = 0, m_bin = 0, m_src = 0, m_ptr = 0;

    gc_conv_arbiter #(.NREQ(N), .W(W), .SW(SW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_gray(out_gray),
        .out_bin(out_bin), .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit [3:0]  vld;
        bit [15:0] data;
        bit        ordy;
        bit [3:0]  erdy;
        bit        eov;
        bit [3:0]  egray;
        bit [3:0]  ebin;
        int        esrc;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gray_of(input int b);
        int g = 0;
        for (int k = 0; k < W - 1; k++) g[k] = b[k] ^ b[k+1];
        g[W-1] = b[W-1];
        return g;
    endfunction

    // Winner is the valid requester at the smallest rotated distance from the pointer.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int best = -1, bd = N;
        for (int i = 0; i < N; i++)
            if (v[i] && ((i - p + N) % N) < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic cycle(input string tag);
        int g, er;
        #1;
        g = pick(req_valid, RR ? m_ptr : 0);
        er = (!rst && (!m_ov || out_ready) && g >= 0) ? (1 << g) : 0;
        chk({tag, "_rdy"}, int'(req_ready), er);
        @(posedge clk);
        if (rst) begin
            m_ov = 0; m_gray = 0; m_bin = 0; m_src = 0; m_ptr = 0;
        end else if (er != 0) begin
            m_ov = 1;
            m_bin = int'(req_data[g*W +: W]);
            m_gray = gray_of(m_bin);
            m_src = g;
            m_ptr = (g + 1) % N;
        end else if (out_ready) m_ov = 0;
        #1;
        chk({tag, "_ov"}, int'(out_valid), int'(m_ov));
        if (m_ov) begin
            chk({tag, "_gray"}, int'(out_gray), m_gray);
            chk({tag, "_bin"}, int'(out_bin), m_bin);
            chk({tag, "_src"}, int'(out_src), m_src);
        end
    endtask

    initial begin
        vt[0]  = '{1, 4'b0100, 16'h0B00, 1, 4'b0000, 0, 4'h0, 4'h0, 0};
        vt[1]  = '{1, 4'b0100, 16'h0B00, 1, 4'b0000, 0, 4'h0, 4'h0, 0};
        vt[2]  = '{0, 4'b0100, 16'h0B00, 1, 4'b0100, 1, 4'hE, 4'hB, 2};
        vt[3]  = '{0, 4'b0000, 16'h0B00, 0, 4'b0000, 1, 4'hE, 4'hB, 2};
        vt[4]  = '{0, 4'b0001, 16'h0005, 0, 4'b0000, 1, 4'hE, 4'hB, 2};
        vt[5]  = '{0, 4'b0001, 16'h0005, 1, 4'b0001, 1, 4'h7, 4'h5, 0};
        vt[6]  = '{0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 4'h0, 0};
        vt[7]  = '{0, 4'b1000, 16'hF000, 0, 4'b1000, 1, 4'h8, 4'hF, 3};
        vt[8]  = '{0, 4'b0010, 16'h0040, 1, 4'b0010, 1, 4'h6, 4'h4, 1};
        vt[9]  = '{0, 4'b0100, 16'h0300, 0, 4'b0000, 1, 4'h6, 4'h4, 1};
        vt[10] = '{0, 4'b0100, 16'h0300, 0, 4'b0000, 1, 4'h6, 4'h4, 1};
        vt[11] = '{0, 4'b0100, 16'h0300, 0, 4'b0000, 1, 4'h6, 4'h4, 1};
        vt[12] = '{0, 4'b0100, 16'h0300, 1, 4'b0100, 1, 4'h2, 4'h3, 2};
        @(posedge clk);
        #1;
        foreach (vt[i]) begin
            rst = vt[i].rst; req_valid = vt[i].vld; req_data = vt[i].data; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("tbl%0d_rdy", i), int'(req_ready), int'(vt[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ov", i), int'(out_valid), int'(vt[i].eov));
            if (vt[i].eov) begin
                chk($sformatf("tbl%0d_gray", i), int'(out_gray), int'(vt[i].egray));
                chk($sformatf("tbl%0d_bin", i), int'(out_bin), int'(vt[i].ebin));
                chk($sformatf("tbl%0d_src", i), int'(out_src), vt[i].esrc);
            end
        end
        rst = 1; req_valid = '0; out_ready = 1;
        cycle("rst");
        rst = 0;
        // Sweep requester 0 through every binary value with no drain stalls.
        for (int b = 0; b < 16; b++) begin
            req_valid = 4'b0001; req_data = 16'(b);
            cycle("sweep");
        end
        rst = 1; req_valid = '0;
        cycle("rst2");
        rst = 0; req_valid = 4'b1111; req_data = 16'h9A5C;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_gnt", int'(req_ready), 1 << (RR ? k % N : 0));
            cycle("fair");
        end
        for (int k = 0; k < 3; k++) cycle("pre_rst");
        out_ready = 0; rst = 1;
        cycle("mid_rst");
        chk("mid_rst_ov", int'(out_valid), 0);
        chk("mid_rst_gray", int'(out_gray), 0);
        chk("mid_rst_src", int'(out_src), 0);
        rst = 0; out_ready = 1;
        #1;
        chk("post_rst_gnt", int'(req_ready), 1);
        cycle("post_rst");
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(39) == 0);
            req_valid = N'($urandom);
            req_data = 16'($urandom);
            out_ready = ($urandom_range(3) != 0);
            cycle("rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
